// File: rtl/onehot_enc_pkg.sv
// ---------------------------------------------------------------------------
// onehot_enc_pkg
// Shared definitions for the one-hot / multi-hot serial index encoder.
//   state_t   : drain FSM states (IDLE, DRAIN)
//   N_DEF     : default input vector width
//   W_DEF     : default index width (clog2 of N_DEF)
//   lsb_index : reference lowest-set-bit search over an N_DEF-wide vector,
//               returns 0 when no bit is set
// ---------------------------------------------------------------------------
package onehot_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int N_DEF = 32;
    localparam int W_DEF = 5;

    // Scanning from the top down lets the last hit win, which is the lowest
    // set bit, without needing a separate "already found" flag.
    function automatic logic [W_DEF-1:0] lsb_index(input logic [N_DEF-1:0] vec);
        logic [W_DEF-1:0] idx;
        idx = '0;
        for (int i = N_DEF - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W_DEF'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_serial_encoder_lsb_finder.sv
// ---------------------------------------------------------------------------
// lsb_finder
// Purely combinational lowest-set-bit finder.
//   vec     in  N  vector to search
//   idx     out W  index of the lowest set bit (0 when vec is all-zero)
//   any_set out 1  at least one bit of vec is set
//   mask    out N  one-hot mask of the found bit (all-zero when vec is zero)
// ---------------------------------------------------------------------------
module lsb_finder #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any_set,
    output logic [N-1:0] mask
);

    // Top-down scan: the final assignment that survives belongs to the
    // lowest set bit, so priority falls out of loop order.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    // vec & -vec isolates the lowest set bit in two's complement, giving the
    // mask used to knock the granted bit out of the pending vector.
    assign mask    = vec & (~vec + N'(1));
    assign any_set = |vec;

endmodule

// File: rtl/onehot_serial_encoder.sv
// ---------------------------------------------------------------------------
// onehot_serial_encoder
// Turns a one-hot or multi-hot request vector back into a serial stream of
// bit indices, lowest index first, one index per output beat.
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   En        in  1   allows acceptance of new vectors (drains always finish)
//   Din       in  N   input vector
//   in_valid  in  1   Din is valid
//   in_ready  out 1   block can accept Din this cycle
//   Dout      out W   index of the currently presented set bit
//   out_valid out 1   Dout is valid
//   out_ready in  1   downstream accepts Dout this cycle
//   out_last  out 1   final beat of the current vector
//   out_zero  out 1   beat stands for an all-zero input vector
//   vec_cnt   out CW  completed vectors, wrapping modulo 2^CW
// ---------------------------------------------------------------------------
module onehot_serial_encoder
    import onehot_enc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          En,
    input  logic [N-1:0]  Din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  Dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          out_zero,
    output logic [CW-1:0] vec_cnt
);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  pending;
    logic [N-1:0]  pending_next;
    logic [W-1:0]  dout_next;
    logic          valid_next;
    logic          last_next;
    logic          zero_next;
    logic [CW-1:0] cnt_next;

    logic [W-1:0]  cur_idx;
    logic          cur_any;
    logic [N-1:0]  cur_mask;
    logic [N-1:0]  src_vec;
    logic [W-1:0]  next_idx;
    logic          next_any;
    logic [N-1:0]  next_mask;
    logic          src_single;
    logic          unused_finder_bits;

    // Finder over the live pending vector; only its mask matters, it clears
    // the bit being granted on a handshake.
    lsb_finder #(.N(N), .W(W)) u_find_cur (
        .vec     (pending),
        .idx     (cur_idx),
        .any_set (cur_any),
        .mask    (cur_mask)
    );

    // Whatever gets presented at the next edge: the fresh Din when idle, or
    // the pending vector with the current beat's bit removed while draining.
    assign src_vec = (state == IDLE) ? Din : (pending & ~cur_mask);

    lsb_finder #(.N(N), .W(W)) u_find_next (
        .vec     (src_vec),
        .idx     (next_idx),
        .any_set (next_any),
        .mask    (next_mask)
    );

    assign unused_finder_bits = ^{cur_idx, cur_any, next_mask};

    // Exactly one bit set means the beat about to be presented is the last.
    assign src_single = next_any && ((src_vec & (src_vec - N'(1))) == '0);

    // rst_n is folded in so the block never advertises readiness while held
    // in reset, even though the state register already reads IDLE.
    assign in_ready = (state == IDLE) && En && rst_n;

    // Next-state and next-output logic; every register holds by default,
    // which is what keeps Dout/flags/pending stable under backpressure.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        dout_next    = Dout;
        valid_next   = out_valid;
        last_next    = out_last;
        zero_next    = out_zero;
        cnt_next     = vec_cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_next   = DRAIN;
                    pending_next = Din;
                    dout_next    = next_idx;
                    valid_next   = 1'b1;
                    last_next    = src_single || !next_any;
                    zero_next    = !next_any;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_next   = IDLE;
                        pending_next = '0;
                        valid_next   = 1'b0;
                        last_next    = 1'b0;
                        zero_next    = 1'b0;
                        cnt_next     = vec_cnt + CW'(1);
                    end else begin
                        pending_next = src_vec;
                        dout_next    = next_idx;
                        last_next    = src_single;
                        zero_next    = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partially drained vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            Dout      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            vec_cnt   <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            Dout      <= dout_next;
            out_valid <= valid_next;
            out_last  <= last_next;
            out_zero  <= zero_next;
            vec_cnt   <= cnt_next;
        end
    end

endmodule
